rom: RTL and testbench



---
 rtl/rom.sv | 34 +++
 tb/tb_rom.sv | 93 +++++++++
 2 files changed

// File: rtl/rom.sv
// rom: fixed 8x8 one-hot lookup table with a registered read port.
// Every cycle reads one word; valid rises on the first edge after reset.
module rom (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] address,
    output logic [7:0] data,
    output logic       valid
);
    logic [7:0] word;
    // default branch returns zero for unknown addresses in simulation
    always_comb begin
        case (address)
            3'd0: word = 8'h01;
            3'd1: word = 8'h02;
            3'd2: word = 8'h04;
            3'd3: word = 8'h08;
            3'd4: word = 8'h10;
            3'd5: word = 8'h20;
            3'd6: word = 8'h40;
            3'd7: word = 8'h80;
            default: word = 8'h00;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= 8'h00;
            valid <= 1'b0;
        end else begin
            data  <= word;
            valid <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rom.sv
// tb_rom: scoreboard bench for rom; expected words are queued when an
// address is driven and compared one edge later.
module tb_rom;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] address = 3'd5;
    logic [7:0] data;
    logic       valid;
    logic [7:0] q[$];
    int total = 0;
    int bad = 0;

    rom dut (.clk(clk), .rst_n(rst_n), .address(address), .data(data), .valid(valid));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [2:0] a);
        return $isunknown(a) ? 8'h00 : 8'h01 << a;
    endfunction

    task automatic pop_check(input string tag);
        logic [7:0] exp;
        if (q.size() == 0) begin
            chk({tag, "_empty"}, 8'hff, 8'h00);
        end else begin
            exp = q.pop_front();
            chk(tag, data, exp);
            chk({tag, "_valid"}, {7'd0, valid}, 8'h01);
        end
    endtask

    task automatic drive(input logic [2:0] a, input string tag);
        address = a;
        q.push_back(model(a));
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_data", data, 8'h00);
            chk("rst_valid", {7'd0, valid}, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) drive(3'd0, "hold0");
        for (int i = 0; i < 8; i++) drive(3'(i), "sweep");
        drive(3'd3, "lat_pre");
        #4;
        address = 3'd6;
        #1;
        chk("lat_hold", data, 8'h08);
        q.push_back(model(3'd6));
        @(posedge clk);
        #1;
        pop_check("lat_post");
        drive(3'd7, "wrap7a");
        drive(3'd0, "wrap0a");
        drive(3'd7, "wrap7b");
        drive(3'd0, "wrap0b");
        for (int i = 0; i < 20; i++) drive(3'($urandom_range(0, 7)), "rand");
        drive(3'd5, "pre_arst");
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_data", data, 8'h00);
        chk("arst_valid", {7'd0, valid}, 8'h00);
        #1;
        rst_n = 1'b1;
        drive(3'd2, "post_arst");
        drive(3'bx, "addr_x");
        drive(3'd3, "after_x");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
